seq_check_param: RTL and testbench

Parametrised serial sequence detector, successor to the fixed 6-bit shift-register checker. It compares a qualified serial bit stream against a runtime-loadable pattern of configurable width. It supports overlapping and non-overlapping detection, suppresses false matches until the history is filled with real data, and keeps a saturating match counter. It sits on the serial data path after the bit-recovery stage and feeds status and interrupt logic.

---
 rtl/seq_check_param.sv | 119 +++++++++++
 tb/tb_seq_check_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_check_param.sv
// Parametrised serial sequence detector with runtime-loadable pattern,
// overlap/non-overlap modes and a saturating match counter.
// Optional per-bit compare mask is enabled by defining SEQ_CHK_MASK_EN.
module seq_check_param #(
    parameter int               SEQ_W    = 6,
    parameter logic [SEQ_W-1:0] SEQ_INIT = 6'b100110,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pat_ld,
    input  logic [SEQ_W-1:0] pat_in,
`ifdef SEQ_CHK_MASK_EN
    input  logic [SEQ_W-1:0] pat_mask_in,
`endif
    input  logic             overlap,
    input  logic             din_vld,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FILL_W = $clog2(SEQ_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_W);
    localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(SEQ_W - 1);

    logic [SEQ_W-1:0]  pat_reg, pat_next;
    logic [SEQ_W-1:0]  hist_reg, hist_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic              match_reg, match_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
`ifdef SEQ_CHK_MASK_EN
    logic [SEQ_W-1:0]  msk_reg, msk_next;
`endif

    logic [SEQ_W-1:0]  nxt;
    logic [SEQ_W-1:0]  diff;
    logic              hit;
    logic [FILL_W-1:0] fill_inc;
    logic [CNT_W-1:0]  cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg   <= SEQ_INIT;
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= 1'b0;
            cnt_reg   <= '0;
`ifdef SEQ_CHK_MASK_EN
            msk_reg   <= '1;
`endif
        end else begin
            pat_reg   <= pat_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            cnt_reg   <= cnt_next;
`ifdef SEQ_CHK_MASK_EN
            msk_reg   <= msk_next;
`endif
        end
    end

    always_comb begin
        nxt  = {hist_reg[SEQ_W-2:0], din};
        diff = nxt ^ pat_reg;
`ifdef SEQ_CHK_MASK_EN
        diff = diff & msk_reg;
`endif
        // Fill gate keeps zero-filled history from matching an all-zero pattern.
        hit      = (fill_reg >= FILL_THR) && (diff == '0);
        fill_inc = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
        cnt_inc  = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

        pat_next   = pat_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        match_next = 1'b0;
        cnt_next   = cnt_reg;
`ifdef SEQ_CHK_MASK_EN
        msk_next   = msk_reg;
`endif

        if (clr) begin
            hist_next = '0;
            fill_next = '0;
            cnt_next  = '0;
        end else if (pat_ld) begin
            pat_next  = pat_in;
`ifdef SEQ_CHK_MASK_EN
            msk_next  = pat_mask_in;
`endif
            hist_next = '0;
            fill_next = '0;
        end else if (din_vld) begin
            if (hit) begin
                match_next = 1'b1;
                cnt_next   = cnt_inc;
                if (overlap) begin
                    // Still advance fill so armed rises on the SEQ_W-th bit even when it hits.
                    hist_next = nxt;
                    fill_next = fill_inc;
                end else begin
                    hist_next = '0;
                    fill_next = '0;
                end
            end else begin
                hist_next = nxt;
                fill_next = fill_inc;
            end
        end
    end

    assign match     = match_reg;
    assign match_cnt = cnt_reg;
    assign armed     = (fill_reg == FILL_FULL);

endmodule

// File: tb/tb_seq_check_param.sv
// Directed self-checking bench for seq_check_param: three instances cover
// the default, 3-bit and 2-bit/2-bit-counter configurations.
module tb_seq_check_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       pat_ld = 1'b0;
    logic       overlap = 1'b1;
    logic       din_vld = 1'b0;
    logic       din = 1'b0;
    logic [5:0] pat_in6 = 6'b100110;
    logic [2:0] pat_in3 = 3'b101;
    logic [1:0] pat_in2 = 2'b11;
`ifdef SEQ_CHK_MASK_EN
    logic [5:0] mask_in6 = 6'b111111;
    logic [2:0] mask_in3 = 3'b111;
    logic [1:0] mask_in2 = 2'b11;
`endif
    logic       match6, armed6, match3, armed3, match2, armed2;
    logic [7:0] cnt6, cnt3;
    logic [1:0] cnt2;

    int checks_passed = 0;
    int checks_total  = 0;

    always #5 clk = ~clk;

    seq_check_param dut6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pat_ld(pat_ld), .pat_in(pat_in6),
`ifdef SEQ_CHK_MASK_EN
        .pat_mask_in(mask_in6),
`endif
        .overlap(overlap), .din_vld(din_vld), .din(din),
        .match(match6), .match_cnt(cnt6), .armed(armed6)
    );

    seq_check_param #(.SEQ_W(3), .SEQ_INIT(3'b101), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pat_ld(pat_ld), .pat_in(pat_in3),
`ifdef SEQ_CHK_MASK_EN
        .pat_mask_in(mask_in3),
`endif
        .overlap(overlap), .din_vld(din_vld), .din(din),
        .match(match3), .match_cnt(cnt3), .armed(armed3)
    );

    seq_check_param #(.SEQ_W(2), .SEQ_INIT(2'b11), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pat_ld(pat_ld), .pat_in(pat_in2),
`ifdef SEQ_CHK_MASK_EN
        .pat_mask_in(mask_in2),
`endif
        .overlap(overlap), .din_vld(din_vld), .din(din),
        .match(match2), .match_cnt(cnt2), .armed(armed2)
    );

    task automatic send(input logic v, input logic b);
        din_vld = v;
        din     = b;
        @(posedge clk);
        #1;
        $display("bit vld=%0b din=%0b | m6=%0b c6=%0d a6=%0b | m3=%0b c3=%0d | m2=%0b c2=%0d a2=%0b",
                 v, b, match6, cnt6, armed6, match3, cnt3, match2, cnt2, armed2);
        din_vld = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic do_load(input logic [5:0] p6, input logic [2:0] p3, input logic [1:0] p2);
        pat_in6 = p6;
        pat_in3 = p3;
        pat_in2 = p2;
        pat_ld  = 1'b1;
        @(posedge clk);
        #1;
        pat_ld  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks_total++;
        if ({match6, cnt6, armed6} !== 10'd0) $display("FAIL reset6 got m=%0b c=%0d a=%0b want 0/0/0", match6, cnt6, armed6);
        else checks_passed++;
        checks_total++;
        if ({match2, cnt2, armed2} !== 4'd0) $display("FAIL reset2 got m=%0b c=%0d a=%0b want 0/0/0", match2, cnt2, armed2);
        else checks_passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reset pattern 100110 is used without any pat_ld.
    task automatic test_default();
        logic [5:0] s;
        s = 6'b100110;
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, s[5-i]);
            checks_total++;
            if (match6 !== (i == 5)) $display("FAIL default_match bit%0d got %0b want %0b", i + 1, match6, (i == 5));
            else checks_passed++;
            checks_total++;
            if (armed6 !== (i == 5)) $display("FAIL default_armed bit%0d got %0b want %0b", i + 1, armed6, (i == 5));
            else checks_passed++;
        end
        checks_total++;
        if (cnt6 !== 8'd1) $display("FAIL default_cnt got %0d want 1", cnt6);
        else checks_passed++;
        send(1'b0, 1'b0);
        checks_total++;
        if ({match6, armed6, cnt6} !== {1'b0, 1'b1, 8'd1}) $display("FAIL default_idle got m=%0b a=%0b c=%0d want 0/1/1", match6, armed6, cnt6);
        else checks_passed++;
    endtask

    task automatic test_overlap_modes();
        logic [4:0] s;
        logic [4:0] want_ov;
        logic [4:0] want_no;
        s       = 5'b10101;
        want_ov = 5'b00101;
        want_no = 5'b00100;
        for (int m = 0; m < 2; m++) begin
            overlap = (m == 0);
            do_clr();
            do_load(6'b100110, 3'b101, 2'b11);
            for (int i = 0; i < 5; i++) begin
                send(1'b1, s[4-i]);
                checks_total++;
                if (match3 !== (m == 0 ? want_ov[4-i] : want_no[4-i]))
                    $display("FAIL ov%0d_match bit%0d got %0b want %0b", 1 - m, i + 1, match3,
                             (m == 0 ? want_ov[4-i] : want_no[4-i]));
                else checks_passed++;
            end
            checks_total++;
            if (cnt3 !== (m == 0 ? 8'd2 : 8'd1)) $display("FAIL ov%0d_cnt got %0d want %0d", 1 - m, cnt3, (m == 0 ? 2 : 1));
            else checks_passed++;
        end
    endtask

    task automatic test_zero_pattern();
        int nvalid;
        overlap = 1'b0;
        do_load(6'b000000, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b0);
            checks_total++;
            if (match6 !== (i == 5)) $display("FAIL zero_match bit%0d got %0b want %0b", i + 1, match6, (i == 5));
            else checks_passed++;
        end
        do_load(6'b000000, 3'b101, 2'b11);
        nvalid = 0;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) nvalid++;
            send((k % 2 == 0), 1'b0);
            checks_total++;
            if (match6 !== ((k % 2 == 0) && nvalid == 6))
                $display("FAIL zero_gap_match cyc%0d got %0b want %0b", k, match6, ((k % 2 == 0) && nvalid == 6));
            else checks_passed++;
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        overlap = 1'b1;
        do_clr();
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 1; i <= 10; i++) begin
            send(1'b1, 1'b1);
            want = (i - 1 >= 3) ? 2'd3 : 2'(i - 1);
            checks_total++;
            if (cnt2 !== want) $display("FAIL sat_cnt bit%0d got %0d want %0d", i, cnt2, want);
            else checks_passed++;
        end
        checks_total++;
        if (match2 !== 1'b1) $display("FAIL sat_match got %0b want 1", match2);
        else checks_passed++;
        do_clr();
        checks_total++;
        if ({cnt2, armed2, match2} !== 4'd0) $display("FAIL sat_clr got c=%0d a=%0b m=%0b want 0/0/0", cnt2, armed2, match2);
        else checks_passed++;
    endtask

    task automatic test_midstream();
        logic [5:0] s;
        s = 6'b100110;
        overlap = 1'b1;
        do_clr();
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 4; i++) send(1'b1, s[5-i]);
        // Reload: a kept history would complete 100110 on the next two bits.
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) begin
            send(1'b1, s[5-i]);
            checks_total++;
            if (match6 !== (i == 5)) $display("FAIL mid_match bit%0d got %0b want %0b", i + 1, match6, (i == 5));
            else checks_passed++;
        end
        for (int i = 0; i < 4; i++) send(1'b1, s[5-i]);
        #2;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if ({match6, cnt6, armed6} !== 10'd0) $display("FAIL async_rst got m=%0b c=%0d a=%0b want 0/0/0", match6, cnt6, armed6);
        else checks_passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mask();
        overlap = 1'b1;
        do_clr();
`ifdef SEQ_CHK_MASK_EN
        mask_in6 = 6'b111100;
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) send(1'b1, (6'b100100 >> (5 - i)) & 6'b1);
        checks_total++;
        if (match6 !== 1'b1) $display("FAIL mask_100100 got %0b want 1", match6);
        else checks_passed++;
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) send(1'b1, (6'b100111 >> (5 - i)) & 6'b1);
        checks_total++;
        if (match6 !== 1'b1) $display("FAIL mask_100111 got %0b want 1", match6);
        else checks_passed++;
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) send(1'b1, (6'b101110 >> (5 - i)) & 6'b1);
        checks_total++;
        if (match6 !== 1'b0) $display("FAIL mask_101110 got %0b want 0", match6);
        else checks_passed++;
`else
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) send(1'b1, (6'b100100 >> (5 - i)) & 6'b1);
        checks_total++;
        if (match6 !== 1'b0) $display("FAIL exact_100100 got %0b want 0", match6);
        else checks_passed++;
        do_load(6'b100110, 3'b101, 2'b11);
        for (int i = 0; i < 6; i++) send(1'b1, (6'b100110 >> (5 - i)) & 6'b1);
        checks_total++;
        if (match6 !== 1'b1) $display("FAIL exact_100110 got %0b want 1", match6);
        else checks_passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_default();
        test_overlap_modes();
        test_zero_pattern();
        test_saturate();
        test_midstream();
        test_mask();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
